// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// A response tag records whether a granted access returns data and which port it belongs to.
package mem_port_arbiter_pkg;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int POLICY_DFIRST = 0;
    localparam int POLICY_RR     = 1;

    typedef struct packed {
        logic valid;
        logic is_d;
    } tag_t;

    function automatic tag_t make_tag(input logic returns_data, input logic owner);
        tag_t t;
        t.valid = returns_data;
        t.is_d  = (owner == REQ_D);
        return t;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
// Shift register of response tags, MEM_LAT stages deep, so each read response
// pops out aligned with mem_rdata. Synchronous clear drops every outstanding tag.
module mem_port_arbiter_resp_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic resetn,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_tag_p [MEM_LAT];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < MEM_LAT; k++) begin
                r_tag_p[k] <= '0;
            end
        end else begin
            r_tag_p[0] <= i_tag;
            for (int k = 1; k < MEM_LAT; k++) begin
                r_tag_p[k] <= r_tag_p[k-1];
            end
        end
    end

    assign o_tag = r_tag_p[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous RAM between instruction fetch and data access,
// granting at most one access per cycle and routing each read response back to its requester.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int POLICY   = 0,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_wmask,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,

    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_wmask,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_SAT = WC_W'(MAX_WAIT);

    logic [WC_W-1:0] r_wait_cnt;
    logic            r_last_d;

    logic w_i_gnt;
    logic w_d_gnt;
    logic w_returns_data;
    tag_t w_tag_in;
    tag_t w_tag_out;

    // Grants are gated by resetn so requests during reset are ignored.
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (resetn) begin
            if (POLICY == POLICY_RR) begin
                if (i_req && d_req) begin
                    w_d_gnt = (r_last_d == REQ_I);
                    w_i_gnt = !w_d_gnt;
                end else begin
                    w_i_gnt = i_req;
                    w_d_gnt = d_req;
                end
            end else begin
                if (i_req && (r_wait_cnt == WAIT_SAT || !d_req)) begin
                    w_i_gnt = 1'b1;
                end else begin
                    w_d_gnt = d_req;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wait_cnt <= '0;
            r_last_d   <= REQ_I;
        end else begin
            if (!i_req || w_i_gnt) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != WAIT_SAT) begin
                r_wait_cnt <= r_wait_cnt + WC_W'(1);
            end
            if (w_i_gnt || w_d_gnt) begin
                r_last_d <= w_d_gnt ? REQ_D : REQ_I;
            end
        end
    end

    assign i_gnt     = w_i_gnt;
    assign d_gnt     = w_d_gnt;
    assign mem_en    = w_i_gnt | w_d_gnt;
    assign mem_addr  = w_d_gnt ? d_addr : i_addr;
    assign mem_wdata = d_wdata;
    assign mem_wmask = (w_d_gnt && d_we) ? d_wmask : '0;

    // Stores are granted but return nothing, so they enter the pipe as an empty tag.
    assign w_returns_data = w_i_gnt | (w_d_gnt & !d_we);
    assign w_tag_in       = make_tag(w_returns_data, w_d_gnt ? REQ_D : REQ_I);

    mem_port_arbiter_resp_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_resp_tag_pipe (
        .clk    (clk),
        .resetn (resetn),
        .i_tag  (w_tag_in),
        .o_tag  (w_tag_out)
    );

    assign i_rvalid = resetn & w_tag_out.valid & !w_tag_out.is_d;
    assign d_rvalid = resetn & w_tag_out.valid &  w_tag_out.is_d;
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (data-first lat 1, round-robin lat 1, data-first lat 2),
// each with a write-first RAM model; grant vectors from a table, read responses via a scoreboard.
module tb_mem_port_arbiter;

    typedef struct {
        int          k;
        bit          rn;
        bit          ir;
        bit          dr;
        bit          dwe;
        logic [3:0]  dm;
        logic [13:0] ia;
        logic [13:0] da;
        logic [31:0] dw;
        bit          eig;
        bit          edg;
        logic [3:0]  ewm;
        bit          drop;
    } vec_t;

    typedef struct {
        int          due;
        bit          is_d;
        logic [31:0] data;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn = 1'b0;
    logic [2:0]  i_req_s = '0, d_req_s = '0, d_we_s = '0;
    logic [13:0] i_addr_s [3];
    logic [13:0] d_addr_s [3];
    logic [3:0]  d_wmask_s [3];
    logic [31:0] d_wdata_s [3];
    logic [2:0]  i_gnt_s, d_gnt_s, i_rvalid_s, d_rvalid_s, mem_en_s;
    logic [31:0] i_rdata_s [3];
    logic [31:0] d_rdata_s [3];
    logic [31:0] mem_wdata_s [3];
    logic [31:0] mem_rdata_s [3];
    logic [3:0]  mem_wmask_s [3];
    logic [13:0] mem_addr_s [3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    sb_t sbq [3][$];
    logic [31:0] shadow [3][256];
    vec_t vt [$];

    function automatic logic [31:0] init_word(input logic [7:0] a);
        return (a == 8'h10) ? 32'h0000_0013 : {16'hC0DE, 8'h00, a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] wm);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int P = (g == 1) ? 1 : 0;
        localparam int L = (g == 2) ? 2 : 1;
        logic [31:0] ram [256];
        logic [31:0] rd_p0, rd_p1;
        bit init_done = 1'b0;

        // Write-first RAM: a read of a word written in the same access returns the new value.
        always @(posedge clk) begin
            if (!init_done) begin
                for (int a = 0; a < 256; a++) ram[a] <= init_word(8'(a));
                init_done <= 1'b1;
            end else if (mem_en_s[g]) begin
                ram[mem_addr_s[g][7:0]] <= merge(ram[mem_addr_s[g][7:0]], mem_wdata_s[g], mem_wmask_s[g]);
                rd_p0 <= merge(ram[mem_addr_s[g][7:0]], mem_wdata_s[g], mem_wmask_s[g]);
            end
            rd_p1 <= rd_p0;
        end
        assign mem_rdata_s[g] = (L == 1) ? rd_p0 : rd_p1;

        mem_port_arbiter #(
            .ADDR_W(14), .DATA_W(32), .MEM_LAT(L), .POLICY(P), .MAX_WAIT(4)
        ) u_dut (
            .clk(clk), .resetn(resetn),
            .i_req(i_req_s[g]), .i_addr(i_addr_s[g]), .i_gnt(i_gnt_s[g]),
            .i_rvalid(i_rvalid_s[g]), .i_rdata(i_rdata_s[g]),
            .d_req(d_req_s[g]), .d_we(d_we_s[g]), .d_wmask(d_wmask_s[g]),
            .d_addr(d_addr_s[g]), .d_wdata(d_wdata_s[g]), .d_gnt(d_gnt_s[g]),
            .d_rvalid(d_rvalid_s[g]), .d_rdata(d_rdata_s[g]),
            .mem_en(mem_en_s[g]), .mem_wmask(mem_wmask_s[g]), .mem_addr(mem_addr_s[g]),
            .mem_wdata(mem_wdata_s[g]), .mem_rdata(mem_rdata_s[g])
        );
    end

    // Response monitor: each due scoreboard entry must appear exactly on its cycle, nothing else may.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (sbq[k].size() != 0 && sbq[k][0].due == cyc) begin
                sb_t e;
                e = sbq[k].pop_front();
                chk($sformatf("i_rvalid k%0d", k), i_rvalid_s[k], !e.is_d);
                chk($sformatf("d_rvalid k%0d", k), d_rvalid_s[k], e.is_d);
                chk($sformatf("rdata k%0d", k), e.is_d ? d_rdata_s[k] : i_rdata_s[k], e.data);
            end else if (i_rvalid_s[k] === 1'b1 || d_rvalid_s[k] === 1'b1) begin
                chk($sformatf("stray rvalid k%0d", k), {i_rvalid_s[k], d_rvalid_s[k]}, 0);
            end
        end
    end

    function automatic vec_t V(input int k, input bit rn, input bit ir, input bit dr, input bit dwe,
                               input logic [3:0] dm, input logic [13:0] ia, input logic [13:0] da,
                               input logic [31:0] dw, input bit eig, input bit edg, input logic [3:0] ewm);
        vec_t v;
        v.k = k; v.rn = rn; v.ir = ir; v.dr = dr; v.dwe = dwe; v.dm = dm;
        v.ia = ia; v.da = da; v.dw = dw; v.eig = eig; v.edg = edg; v.ewm = ewm; v.drop = 1'b0;
        return v;
    endfunction

    function automatic vec_t IDLE(input int k, input bit rn);
        return V(k, rn, 0, 0, 0, 4'h0, 14'h0, 14'h0, 32'h0, 0, 0, 4'h0);
    endfunction

    task automatic apply(input vec_t v);
        int lat;
        @(posedge clk);
        #1;
        resetn  = v.rn;
        i_req_s = '0;
        d_req_s = '0;
        d_we_s  = '0;
        i_req_s[v.k]   = v.ir;
        d_req_s[v.k]   = v.dr;
        d_we_s[v.k]    = v.dwe;
        d_wmask_s[v.k] = v.dm;
        i_addr_s[v.k]  = v.ia;
        d_addr_s[v.k]  = v.da;
        d_wdata_s[v.k] = v.dw;
        lat = (v.k == 2) ? 2 : 1;
        if (!v.drop) begin
            if (v.eig) sbq[v.k].push_back('{cyc + lat, 1'b0, shadow[v.k][v.ia[7:0]]});
            if (v.edg && !v.dwe) sbq[v.k].push_back('{cyc + lat, 1'b1, shadow[v.k][v.da[7:0]]});
        end
        if (v.edg && v.dwe) shadow[v.k][v.da[7:0]] = merge(shadow[v.k][v.da[7:0]], v.dw, v.dm);
        #3;
        chk($sformatf("i_gnt k%0d", v.k), i_gnt_s[v.k], v.eig);
        chk($sformatf("d_gnt k%0d", v.k), d_gnt_s[v.k], v.edg);
        chk($sformatf("mem_en k%0d", v.k), mem_en_s[v.k], v.eig | v.edg);
        chk($sformatf("mem_wmask k%0d", v.k), mem_wmask_s[v.k], v.ewm);
        if (v.eig) chk($sformatf("mem_addr(i) k%0d", v.k), mem_addr_s[v.k], v.ia);
        else if (v.edg) chk($sformatf("mem_addr(d) k%0d", v.k), mem_addr_s[v.k], v.da);
        if (v.edg && v.dwe) chk($sformatf("mem_wdata k%0d", v.k), mem_wdata_s[v.k], v.dw);
        if (!v.rn) begin
            chk($sformatf("reset i_rvalid k%0d", v.k), i_rvalid_s[v.k], 1'b0);
            chk($sformatf("reset d_rvalid k%0d", v.k), d_rvalid_s[v.k], 1'b0);
        end
    endtask

    initial begin
        vec_t v;
        for (int k = 0; k < 3; k++) begin
            i_addr_s[k] = '0; d_addr_s[k] = '0; d_wmask_s[k] = '0; d_wdata_s[k] = '0;
            for (int a = 0; a < 256; a++) shadow[k][a] = init_word(8'(a));
        end

        // Reset with requests pending on every instance: all must be ignored.
        for (int k = 0; k < 3; k++) apply(V(k, 0, 1, 1, 1, 4'hF, 14'h010, 14'h020, 32'hDEAD, 0, 0, 4'h0));

        // Fetch only on data-first instance.
        vt.push_back(V(0, 1, 1, 0, 0, 4'h0, 14'h010, 14'h0, 32'h0, 1, 0, 4'h0));
        vt.push_back(IDLE(0, 1));
        // Both loads held: D x4 then forced I, period 5.
        for (int c = 0; c < 11; c++)
            vt.push_back(V(0, 1, 1, 1, 0, 4'h0, 14'h020, 14'(14'h030 + c), 32'h0, (c % 5 == 4), (c % 5 != 4), 4'h0));
        vt.push_back(IDLE(0, 1));
        // Fetch dropped mid-wait restarts the starvation count.
        vt.push_back(V(0, 1, 1, 1, 0, 4'h0, 14'h021, 14'h040, 32'h0, 0, 1, 4'h0));
        vt.push_back(V(0, 1, 1, 1, 0, 4'h0, 14'h021, 14'h040, 32'h0, 0, 1, 4'h0));
        vt.push_back(V(0, 1, 0, 1, 0, 4'h0, 14'h000, 14'h041, 32'h0, 0, 1, 4'h0));
        for (int c = 0; c < 5; c++)
            vt.push_back(V(0, 1, 1, 1, 0, 4'h0, 14'h022, 14'h042, 32'h0, (c == 4), (c != 4), 4'h0));
        vt.push_back(IDLE(0, 1));
        // Round-robin: alternate under contention, single requester always wins.
        for (int c = 0; c < 4; c++)
            vt.push_back(V(1, 1, 1, 1, 0, 4'h0, 14'h050, 14'h060, 32'h0, (c % 2 == 1), (c % 2 == 0), 4'h0));
        vt.push_back(V(1, 1, 1, 0, 0, 4'h0, 14'h051, 14'h000, 32'h0, 1, 0, 4'h0));
        vt.push_back(V(1, 1, 0, 1, 0, 4'h0, 14'h000, 14'h061, 32'h0, 0, 1, 4'h0));
        vt.push_back(V(1, 1, 1, 1, 0, 4'h0, 14'h052, 14'h062, 32'h0, 1, 0, 4'h0));
        vt.push_back(IDLE(1, 1));
        // Byte store then load-after-write; load with a stray mask must not write.
        vt.push_back(V(0, 1, 0, 1, 1, 4'b0100, 14'h000, 14'h005, 32'h00AB_0000, 0, 1, 4'b0100));
        vt.push_back(V(0, 1, 0, 1, 0, 4'hF, 14'h000, 14'h005, 32'hFFFF_FFFF, 0, 1, 4'h0));
        vt.push_back(V(0, 1, 1, 1, 1, 4'b0011, 14'h011, 14'h006, 32'h1234_5678, 0, 1, 4'b0011));
        vt.push_back(V(0, 1, 1, 0, 0, 4'h0, 14'h011, 14'h000, 32'h0, 1, 0, 4'h0));
        vt.push_back(V(0, 1, 0, 1, 0, 4'h0, 14'h000, 14'h006, 32'h0, 0, 1, 4'h0));
        vt.push_back(IDLE(0, 1));
        // Latency 2, back-to-back I, D, I.
        vt.push_back(V(2, 1, 1, 0, 0, 4'h0, 14'h040, 14'h000, 32'h0, 1, 0, 4'h0));
        vt.push_back(V(2, 1, 0, 1, 0, 4'h0, 14'h000, 14'h041, 32'h0, 0, 1, 4'h0));
        vt.push_back(V(2, 1, 1, 0, 0, 4'h0, 14'h042, 14'h000, 32'h0, 1, 0, 4'h0));
        for (int c = 0; c < 3; c++) vt.push_back(IDLE(2, 1));

        foreach (vt[n]) apply(vt[n]);

        // Fetch granted, then reset for two cycles: its response must vanish.
        v = V(0, 1, 1, 0, 0, 4'h0, 14'h010, 14'h000, 32'h0, 1, 0, 4'h0);
        v.drop = 1'b1;
        apply(v);
        apply(V(0, 0, 1, 1, 0, 4'h0, 14'h010, 14'h020, 32'h0, 0, 0, 4'h0));
        apply(V(0, 0, 1, 1, 0, 4'h0, 14'h010, 14'h020, 32'h0, 0, 0, 4'h0));
        apply(IDLE(0, 1));
        apply(IDLE(0, 1));

        // Latency-2 fetch followed by a single reset cycle: still in flight, must be dropped.
        v = V(2, 1, 1, 0, 0, 4'h0, 14'h043, 14'h000, 32'h0, 1, 0, 4'h0);
        v.drop = 1'b1;
        apply(v);
        apply(IDLE(2, 0));
        for (int c = 0; c < 3; c++) apply(IDLE(2, 1));

        // Build up wait_cnt with stores, reset, then fetch must wait the full MAX_WAIT again.
        for (int c = 0; c < 3; c++) apply(V(0, 1, 1, 1, 1, 4'h1, 14'h070, 14'h071, 32'h55, 0, 1, 4'h1));
        apply(IDLE(0, 0));
        for (int c = 0; c < 5; c++)
            apply(V(0, 1, 1, 1, 0, 4'h0, 14'h072, 14'h073, 32'h0, (c == 4), (c != 4), 4'h0));

        for (int c = 0; c < 4; c++) apply(IDLE(0, 1));
        for (int k = 0; k < 3; k++) chk($sformatf("responses pending k%0d", k), sbq[k].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
